// File: rtl/ycrcb_scan_pkg.sv
// Shared types and constants for the 8x8 YCrCb block scanner.
// The scan table is also reused by the decoder's inverse scan.
package ycrcb_scan_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam int BLK_N  = 8;
  localparam int BLK_SZ = 64;

  // Entry k is the raster position {row[2:0], col[2:0]} of zigzag beat k.
  localparam logic [5:0] ZZ_LUT [BLK_SZ] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zigzag_lut.sv
// Combinational scan index -> (row, col) mapping; JPEG zigzag when ZIGZAG=1,
// row-major raster otherwise.
module zigzag_lut
  import ycrcb_scan_pkg::*;
#(
  parameter int ZIGZAG = 1
) (
  input  logic [5:0] idx,
  output logic [2:0] row,
  output logic [2:0] col
);

  generate
    if (ZIGZAG != 0) begin : g_zigzag
      assign {row, col} = ZZ_LUT[idx];
    end else begin : g_raster
      assign {row, col} = idx;
    end
  endgenerate

endmodule

// File: rtl/ycrcb_zigzag_scan.sv
// Snapshots an 8x8 block on full_i, acknowledges with finish_o and streams
// the 64 samples in scan order. Optional LEVEL_SHIFT_EN makes samples signed.
module ycrcb_zigzag_scan
  import ycrcb_scan_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ZIGZAG = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       full_i,
  input  logic [BLK_N-1:0][BLK_N-1:0][DATA_W-1:0]    blk_i,
  output logic                                       finish_o,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [DATA_W-1:0]                          out_data,
  output logic [5:0]                                 out_idx,
  output logic                                       out_last,
  output logic                                       busy,
  output state_e                                     dbg_state
);

  // Handshake: a beat transfers on any rising edge where out_valid and
  // out_ready are both high; while out_valid=1 and out_ready=0 the beat
  // (data, idx, last) is held unchanged and out_valid never drops mid-block.

  state_e                                   state_q, state_n;
  logic [5:0]                               idx_q, idx_n;
  logic                                     pending_q, pending_n;
  logic                                     finish_q, finish_n;
  logic                                     capture;
  logic                                     hs, last_hs;
  logic [BLK_N-1:0][BLK_N-1:0][DATA_W-1:0]  local_q;
  logic [2:0]                               row, col;
  logic [DATA_W-1:0]                        sample;
  logic [DATA_W-1:0]                        shaped;

  assign out_valid = (state_q == STREAM);
  assign hs        = out_valid & out_ready;
  assign last_hs   = hs & (idx_q == 6'(BLK_SZ - 1));

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    pending_n = pending_q;
    finish_n  = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_i) begin
          capture  = 1'b1;
          finish_n = 1'b1;
          idx_n    = 6'd0;
          state_n  = STREAM;
        end
      end
      STREAM: begin
        if (last_hs) begin
          idx_n = 6'd0;
          // A full_i landing on the final beat counts as already pending.
          if (pending_q || full_i) begin
            capture   = 1'b1;
            finish_n  = 1'b1;
            pending_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (hs) idx_n = idx_q + 6'd1;
          if (full_i) pending_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 6'd0;
      pending_q <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      pending_q <= pending_n;
      finish_q  <= finish_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      local_q <= '0;
    end else if (capture) begin
      local_q <= blk_i;
    end
  end

  zigzag_lut #(.ZIGZAG(ZIGZAG)) u_lut (
    .idx (idx_q),
    .row (row),
    .col (col)
  );

  assign sample = local_q[row][col];

`ifdef LEVEL_SHIFT_EN
  assign shaped = {~sample[DATA_W-1], sample[DATA_W-2:0]};
`else
  assign shaped = sample;
`endif

  // Outputs read as zero whenever no beat is on offer.
  assign out_data  = out_valid ? shaped : '0;
  assign out_idx   = idx_q;
  assign out_last  = out_valid & (idx_q == 6'(BLK_SZ - 1));
  assign finish_o  = finish_q;
  assign busy      = (state_q != IDLE) | pending_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ycrcb_zigzag_scan.sv
// Self-checking bench: zigzag and raster instances side by side against a
// diagonal-walk reference model with an expected-value scoreboard.
module tb_ycrcb_zigzag_scan;
  import ycrcb_scan_pkg::*;

  typedef logic [7:0][7:0][7:0] blk_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       full_i;
  logic       out_ready;
  blk_t       blk_i;

  logic       fin_z, val_z, last_z, busy_z;
  logic [7:0] data_z;
  logic [5:0] idx_z;
  state_e     st_z;
  logic       fin_r, val_r, last_r, busy_r;
  logic [7:0] data_r;
  logic [5:0] idx_r;
  state_e     st_r;

  int         n_pass = 0;
  int         n_chk  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_r_q[$];
  int         zz_pos[64];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ycrcb_zigzag_scan #(.DATA_W(8), .ZIGZAG(1)) dut_z (
    .clk(clk), .rst(rst), .full_i(full_i), .blk_i(blk_i),
    .finish_o(fin_z), .out_valid(val_z), .out_ready(out_ready),
    .out_data(data_z), .out_idx(idx_z), .out_last(last_z),
    .busy(busy_z), .dbg_state(st_z)
  );

  ycrcb_zigzag_scan #(.DATA_W(8), .ZIGZAG(0)) dut_r (
    .clk(clk), .rst(rst), .full_i(full_i), .blk_i(blk_i),
    .finish_o(fin_r), .out_valid(val_r), .out_ready(out_ready),
    .out_data(data_r), .out_idx(idx_r), .out_last(last_r),
    .busy(busy_r), .dbg_state(st_r)
  );

  // ---------------- reference model ----------------
  // Zigzag order by walking anti-diagonals, alternating direction.
  task automatic build_zigzag();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_pos[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_pos[k] = r * 8 + (s - r); k++; end
      end
    end
  endtask

  function automatic logic [7:0] visible(input logic [7:0] s);
`ifdef LEVEL_SHIFT_EN
    return s - 8'd128;
`else
    return s;
`endif
  endfunction

  task automatic push_block(input blk_t b);
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back(visible(b[zz_pos[k] / 8][zz_pos[k] % 8]));
      exp_r_q.push_back(visible(b[k / 8][k % 8]));
    end
  endtask

  function automatic blk_t rand_block();
    blk_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r][c] = 8'($urandom_range(0, 255));
    return b;
  endfunction

  function automatic blk_t ramp_block(input int base);
    blk_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r][c] = 8'((8 * r + c + base) % 256);
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a block and pulses full_i for one edge; returns at the sample
  // point of the cycle after capture.
  task automatic start_block(input blk_t b);
    blk_i  = b;
    full_i = 1'b1;
    push_block(b);
    step();
    full_i = 1'b0;
  endtask

  // Scoreboard loop: consumes beats until out_valid drops.
  task automatic drain(input string tag, input bit rand_ready, input int pend_at,
                       input blk_t pend_blk, input bit fin_first);
    int         beat = 0;
    int         stall_cnt = 0;
    int         guard;
    bit         pend = 1'b0;
    bit         pend_done = 1'b0;
    bit         exp_fin = fin_first;
    bit         stalled = 1'b0;
    logic [7:0] hd;
    logic [5:0] hi;
    for (guard = 0; guard < 3000; guard++) begin
      full_i = 1'b0;
      n_chk++;
      if (fin_z !== exp_fin || fin_r !== exp_fin) begin
        $display("FAIL %s finish beat=%0d got z=%b r=%b want %b", tag, beat, fin_z, fin_r, exp_fin);
      end else n_pass++;
      exp_fin = 1'b0;
      if (stalled) begin
        n_chk++;
        if (data_z !== hd || idx_z !== hi || val_z !== 1'b1) begin
          $display("FAIL %s stall_hold got data=%h idx=%0d v=%b want data=%h idx=%0d v=1",
                   tag, data_z, idx_z, val_z, hd, hi);
        end else n_pass++;
      end
      if (val_z !== 1'b1 && exp_q.size() == 0) break;
      n_chk++;
      if (val_z !== 1'b1 || val_r !== 1'b1 || busy_z !== 1'b1) begin
        $display("FAIL %s valid_mid_block beat=%0d got v=%b vr=%b busy=%b want 1 1 1",
                 tag, beat, val_z, val_r, busy_z);
        break;
      end else n_pass++;
      if (rand_ready) begin
        if (beat == 10 && stall_cnt < 5) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else out_ready = 1'($urandom_range(0, 1));
      end else out_ready = 1'b1;
      if (pend_at == beat && !pend_done) begin
        blk_i     = pend_blk;
        full_i    = 1'b1;
        push_block(pend_blk);
        pend_done = 1'b1;
        pend      = 1'b1;
      end
      if (out_ready) begin
        logic [7:0] e = exp_q.pop_front();
        logic [7:0] er = exp_r_q.pop_front();
        n_chk++;
        if ({data_z, idx_z, last_z} !== {e, 6'(beat), 1'(beat == 63)}) begin
          $display("FAIL %s zigzag_beat got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                   tag, data_z, idx_z, last_z, e, beat, beat == 63);
        end else n_pass++;
        n_chk++;
        if ({data_r, idx_r, last_r} !== {er, 6'(beat), 1'(beat == 63)}) begin
          $display("FAIL %s raster_beat got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                   tag, data_r, idx_r, last_r, er, beat, beat == 63);
        end else n_pass++;
        if (beat == 63) begin
          exp_fin = pend;
          pend    = 1'b0;
          beat    = 0;
        end else beat++;
      end
      stalled = !out_ready;
      hd      = data_z;
      hi      = idx_z;
      step();
    end
    full_i    = 1'b0;
    out_ready = 1'b1;
    n_chk++;
    if (guard >= 3000 || exp_q.size() != 0) begin
      $display("FAIL %s drain_end got left=%0d guard=%0d want left=0", tag, exp_q.size(), guard);
    end else n_pass++;
    n_chk++;
    if (val_z !== 1'b0 || busy_z !== 1'b0 || st_z !== IDLE) begin
      $display("FAIL %s idle_after got v=%b busy=%b want 0 0", tag, val_z, busy_z);
    end else n_pass++;
    exp_q.delete();
    exp_r_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; full_i = 1'b0; out_ready = 1'b0; blk_i = '0;
    step(); step();
    n_chk++;
    if ({fin_z, val_z, data_z, idx_z, last_z, busy_z} !== 18'd0 ||
        {fin_r, val_r, data_r, idx_r, last_r, busy_r} !== 18'd0) begin
      $display("FAIL reset_values got z=%h r=%h want 0",
               {fin_z, val_z, data_z, idx_z, last_z, busy_z},
               {fin_r, val_r, data_r, idx_r, last_r, busy_r});
    end else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_raster_value();
    out_ready = 1'b1;
    n_chk++;
    if (fin_z !== 1'b0) $display("FAIL raster pre_finish got %b want 0", fin_z);
    else n_pass++;
    start_block(ramp_block(0));
    n_chk++;
    if (val_z !== 1'b1 || idx_z !== 6'd0 || data_z !== visible(8'd0)) begin
      $display("FAIL raster latency got v=%b idx=%0d data=%h want v=1 idx=0 data=%h",
               val_z, idx_z, data_z, visible(8'd0));
    end else n_pass++;
    drain("raster", 1'b0, -1, '0, 1'b1);
  endtask

  task automatic test_backpressure();
    start_block(rand_block());
    drain("backpressure", 1'b1, -1, '0, 1'b1);
  endtask

  task automatic test_pending();
    start_block(rand_block());
    drain("pending", 1'b0, 20, ramp_block(64), 1'b1);
  endtask

  task automatic test_pending_stalled();
    start_block(ramp_block(7));
    drain("pending_stall", 1'b1, 40, rand_block(), 1'b1);
  endtask

  task automatic test_level_shift();
    blk_t b = '0;
    b[0][0] = 8'hFF;
    start_block(b);
    drain("level_shift", 1'b0, -1, '0, 1'b1);
  endtask

  task automatic test_async_reset();
    int guard;
    out_ready = 1'b1;
    start_block(rand_block());
    for (guard = 0; guard < 200; guard++) begin
      full_i = (idx_z == 6'd5);
      if (idx_z == 6'd30) break;
      step();
    end
    full_i = 1'b0;
    n_chk++;
    if (guard >= 200 || busy_z !== 1'b1) begin
      $display("FAIL async_reset reach_beat30 got idx=%0d busy=%b want 30 1", idx_z, busy_z);
    end else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({fin_z, val_z, data_z, idx_z, last_z, busy_z} !== 18'd0 ||
        {fin_r, val_r, data_r, idx_r, last_r, busy_r} !== 18'd0) begin
      $display("FAIL async_reset immediate got z=%h r=%h want 0",
               {fin_z, val_z, data_z, idx_z, last_z, busy_z},
               {fin_r, val_r, data_r, idx_r, last_r, busy_r});
    end else n_pass++;
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_r_q.delete();
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if (val_z !== 1'b0 || fin_z !== 1'b0 || busy_z !== 1'b0 || val_r !== 1'b0) begin
        $display("FAIL async_reset quiet cyc=%0d got v=%b fin=%b busy=%b want 0 0 0",
                 i, val_z, fin_z, busy_z);
      end else n_pass++;
    end
    start_block(rand_block());
    drain("after_reset", 1'b1, -1, '0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    full_i = 1'b0;
    out_ready = 1'b0;
    blk_i = '0;
    build_zigzag();
    test_reset();
    test_raster_value();
    test_backpressure();
    test_pending();
    test_pending_stalled();
    test_level_shift();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ycrcb_zigzag_scan.md
Name: ycrcb_zigzag_scan

Overview:
- Downstream consumer of the 8x8 YCrCb block buffer.
- On the buffer's one-cycle full pulse it snapshots the 8x8 block into a local copy and returns a one-cycle finish pulse, releasing the buffer for refill.
- Then streams the 64 samples, one per beat, over a valid/ready interface in JPEG zigzag (or raster) order, feeding the 2D-DCT/quantiser stage.
- A full pulse arriving while a block is still streaming is held pending; the buffer stays frozen until it is serviced.

Parameters:
DATA_W, 8, sample width in bits
ZIGZAG, 1, 1 = JPEG zigzag scan order; 0 = raster order (row-major)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
full_i  input  1  one-cycle pulse from block buffer: 8x8 block complete and stable
blk_i  input  [DATA_W-1:0] x [7:0][7:0]  block buffer contents, indexed [row][col]
finish_o  output  1  one-cycle pulse to block buffer: block consumed, buffer may clear
out_valid  output  1  out_data/out_idx/out_last valid
out_ready  input  1  downstream accepts beat when out_valid and out_ready
out_data  output  DATA_W  sample (level-shifted if LEVEL_SHIFT_EN)
out_idx  output  6  scan index 0..63 of current beat
out_last  output  1  high on beat out_idx==63
busy  output  1  high while state != IDLE or pending set

Behaviour:
- Reset values: finish_o=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, pending=0, local buffer all 0, state IDLE.
- Reset mid-stream aborts the block; the remaining beats and any pending block are discarded.
- States:
  - IDLE -> STREAM when full_i=1.
  - STREAM -> STREAM on the beat-63 handshake if pending=1 (re-capture).
  - STREAM -> IDLE on the beat-63 handshake if pending=0.
- Capture (IDLE, full_i=1 at edge t):
  - Copy blk_i into the local buffer and set idx=0.
  - Cycle t+1: finish_o=1 for exactly one cycle; out_valid=1 with idx 0.
  - Latency: full_i to first valid beat = 1 cycle.
- STREAM:
  - out_valid held high; out_data = local[row(idx)][col(idx)].
  - row/col come from the scan LUT when ZIGZAG=1, else row=idx[5:3], col=idx[2:0].
  - On handshake, idx increments; out_data/out_idx/out_last are stable while out_valid=1 and out_ready=0.
  - One beat per cycle max; out_valid never deasserts mid-block.
- full_i during STREAM:
  - Set pending=1 and do not pulse finish_o.
  - The buffer remains in its hold state, so blk_i stays stable.
- End of block (beat 63 handshake):
  - pending=1: capture blk_i at that same edge, clear pending, pulse finish_o next cycle, continue with idx=0 (no bubble).
  - pending=0: go to IDLE, out_valid=0 next cycle.
- full_i coincident with the beat-63 handshake is treated as pending=1 (immediate re-capture).
- A second full_i while pending=1 cannot occur (the buffer is frozen); if it does, it is ignored.
- full_i in IDLE is never lost; full_i is single-cycle and only sampled, never stretched.

Optional Feature:
- Macro: LEVEL_SHIFT_EN.
- Defined: out_data = sample - 2^(DATA_W-1), two's complement (MSB inverted); e.g. 0x00 -> 0x80, 0xFF -> 0x7F, 0x80 -> 0x00.
- Undefined: out_data = raw unsigned sample.
- Timing and handshake are identical in both cases.

Decomposition:
- Package ycrcb_scan_pkg:
  - state enum {IDLE, STREAM}
  - BLK_N=8, BLK_SZ=64 constants
  - zigzag LUT: 64-entry constant array of {row[2:0], col[2:0]} in JPEG order.
- Sub-module zigzag_lut: combinational idx -> {row,col}, selected by ZIGZAG. It is the natural split and is reusable by the inverse scan in the decoder.

Test Plan:
- Raster value test:
  - Stimulus: reset; blk_i[r][c]=8r+c; pulse full_i; out_ready=1; ZIGZAG=1, no LEVEL_SHIFT_EN.
  - Response: finish_o pulses 1 cycle after full_i; beats 0..5 = 0,1,8,16,9,2; beat 63 = 63 with out_last=1; exactly 64 beats; then out_valid=0.
- ZIGZAG=0:
  - Stimulus: same block.
  - Response: beats are 0,1,2,...,63 in order.
- Backpressure:
  - Stimulus: toggle out_ready randomly (including 5-cycle stalls at idx 10).
  - Response: out_data/out_idx held stable during stalls; sequence identical to the unstalled run.
- Pending block:
  - Stimulus: second full_i at beat 20 with blk_i=8r+c+64 mod 256.
  - Response: no finish_o until the beat-63 handshake; finish_o the cycle after; next beat idx 0 = 64; no idle cycle between blocks.
- LEVEL_SHIFT_EN:
  - Stimulus: block all 0x00 except [0][0]=0xFF.
  - Response: beat 0 = 0x7F, others 0x80.
- Async reset:
  - Stimulus: assert rst at beat 30 with pending=1.
  - Response: all outputs 0 immediately; after release no beats until a new full_i.
